// File: rtl/ad9911_cfg_sequencer_if.sv
// Command/handshake bundle between the AD9911 config sequencer and its environment.
// TR is a level request, and it only rises while the writer is idle. The writer
// accepts a request by lowering OVER. The request is then complete when OVER
// returns high, and only after that may the next TR be raised.
interface ad9911_cfg_sequencer_if;
  logic        START;
  logic [31:0] FREQ_WORD;
  logic [13:0] PHASE_WORD;
  logic [9:0]  AMP_WORD;
  logic        OVER;
  logic        TR;
  logic [7:0]  REG_ADDR;
  logic [31:0] DATA_IN;
  logic        BUSY;
  logic        INIT_DONE;
  logic        UPD_DONE;
  logic        ERR;

  modport master (
    input  START, FREQ_WORD, PHASE_WORD, AMP_WORD, OVER,
    output TR, REG_ADDR, DATA_IN, BUSY, INIT_DONE, UPD_DONE, ERR
  );

  modport slave (
    output START, FREQ_WORD, PHASE_WORD, AMP_WORD, OVER,
    input  TR, REG_ADDR, DATA_IN, BUSY, INIT_DONE, UPD_DONE, ERR
  );
endinterface

// File: rtl/ad9911_cfg_sequencer.sv
// AD9911 register write sequencer: static init writes after reset, then tuning
// updates (CTW0, CPOW0, ACR) on START, each paced on the serial writer's OVER flag.
module ad9911_cfg_sequencer #(
  parameter logic [7:0]  CSR_INIT = 8'h00,
  parameter logic [23:0] FR1_INIT = 24'hD00000,
  parameter logic [15:0] FR2_INIT = 16'h0000,
  parameter logic [23:0] CFR_INIT = 24'h000302,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  ad9911_cfg_sequencer_if.master bus,
  output logic [3:0]             state_dbg
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_BOOT  = 4'd0,
    S_CSR   = 4'd1,
    S_FR1   = 4'd2,
    S_FR2   = 4'd3,
    S_CFR   = 4'd4,
    S_READY = 4'd5,
    S_CTW   = 4'd6,
    S_POW   = 4'd7,
    S_ACR   = 4'd8
  } state_t;

  state_t        state, state_nx;
  logic          wait_q, wait_nx;
  logic [CW-1:0] cnt_q, cnt_nx;
  logic [31:0]   freq_q;
  logic [13:0]   phase_q;
  logic [9:0]    amp_q;
  logic          init_done_q, upd_done_q, err_q;
  logic          capture, init_set, upd_set, set_err;
  logic          is_write;

  assign is_write = !(state inside {S_BOOT, S_READY});

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= S_BOOT;
      wait_q      <= 1'b0;
      cnt_q       <= '0;
      freq_q      <= '0;
      phase_q     <= '0;
      amp_q       <= '0;
      init_done_q <= 1'b0;
      upd_done_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state      <= state_nx;
      wait_q     <= wait_nx;
      cnt_q      <= cnt_nx;
      upd_done_q <= upd_set;
      if (capture) begin
        freq_q  <= bus.FREQ_WORD;
        phase_q <= bus.PHASE_WORD;
        amp_q   <= bus.AMP_WORD;
      end
      if (init_set) init_done_q <= 1'b1;
      if (set_err)  err_q       <= 1'b1;
    end
  end

  // wait_q selects the write sub-phase: 0 = request issued, 1 = transfer running.
  always_comb begin
    state_nx = state;
    wait_nx  = wait_q;
    cnt_nx   = cnt_q;
    capture  = 1'b0;
    init_set = 1'b0;
    upd_set  = 1'b0;
    set_err  = 1'b0;
    case (state)
      S_BOOT: state_nx = S_CSR;
      S_READY: begin
        if (bus.START) begin
          capture  = 1'b1;
          state_nx = S_CTW;
          wait_nx  = 1'b0;
          cnt_nx   = '0;
        end
      end
      default: begin
        if (!wait_q) begin
          if (!bus.OVER) begin
            wait_nx = 1'b1;
            cnt_nx  = '0;
          end else if (cnt_q == CNT_LAST) begin
            set_err  = 1'b1;
            state_nx = S_READY;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt_q + 1'b1;
          end
        end else if (bus.OVER) begin
          wait_nx = 1'b0;
          case (state)
            S_CSR: state_nx = S_FR1;
            S_FR1: state_nx = S_FR2;
            S_FR2: state_nx = S_CFR;
            S_CFR: begin
              state_nx = S_READY;
              init_set = 1'b1;
            end
            S_CTW: state_nx = S_POW;
            S_POW: state_nx = S_ACR;
            S_ACR: begin
              state_nx = S_READY;
              upd_set  = 1'b1;
            end
            default: state_nx = S_READY;
          endcase
        end
      end
    endcase
  end

  // Address/data are decoded from the state so they are stable for the whole write.
  always_comb begin
    bus.REG_ADDR = 8'h00;
    bus.DATA_IN  = 32'h0;
    case (state)
      S_CSR: begin bus.REG_ADDR = 8'h00; bus.DATA_IN = {24'b0, CSR_INIT}; end
      S_FR1: begin bus.REG_ADDR = 8'h01; bus.DATA_IN = {8'b0, FR1_INIT};  end
      S_FR2: begin bus.REG_ADDR = 8'h02; bus.DATA_IN = {16'b0, FR2_INIT}; end
      S_CFR: begin bus.REG_ADDR = 8'h03; bus.DATA_IN = {8'b0, CFR_INIT};  end
      S_CTW: begin bus.REG_ADDR = 8'h04; bus.DATA_IN = freq_q;            end
      S_POW: begin bus.REG_ADDR = 8'h05; bus.DATA_IN = {18'b0, phase_q};  end
      S_ACR: begin bus.REG_ADDR = 8'h06; bus.DATA_IN = {19'b0, 1'b1, 2'b0, amp_q}; end
      default: ;
    endcase
  end

  assign bus.TR        = is_write && !wait_q;
  assign bus.BUSY      = (state != S_READY);
  assign bus.INIT_DONE = init_done_q;
  assign bus.UPD_DONE  = upd_done_q;
  assign bus.ERR       = err_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_ad9911_cfg_sequencer.sv
// Bench for ad9911_cfg_sequencer: behavioural writer, transaction scoreboard and
// directed plus randomized init/update/timeout/reset scenarios.
module tb_ad9911_cfg_sequencer;
  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [3:0] state_dbg;

  ad9911_cfg_sequencer_if bus();

  ad9911_cfg_sequencer dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  logic [39:0] exp_q[$];
  logic [39:0] got_q[$];
  int tr_run_q[$];
  int lat = 1;
  int dur = 2;
  bit stall = 1'b0;
  int viol = 0;
  int wr_st = 0;
  int wr_cnt = 0;
  int run = 0;
  int pulses;
  logic [31:0] f0, f1;
  logic [13:0] p0;
  logic [9:0]  a0;

  // Writer: OVER falls so that TR is seen high for 'lat' cycles, stays low 'dur' cycles.
  always @(negedge CLK) begin
    if (bus.TR === 1'b1 && bus.OVER === 1'b0) viol++;
    if (bus.TR === 1'b1) run++;
    else if (run > 0) begin
      tr_run_q.push_back(run);
      run = 0;
    end
    if (!RESET_N) begin
      wr_st = 0;
      bus.OVER = 1'b1;
    end else begin
      case (wr_st)
        0: if (bus.TR === 1'b1 && !stall) begin
          got_q.push_back({bus.REG_ADDR, bus.DATA_IN});
          if (lat <= 1) begin
            bus.OVER = 1'b0;
            wr_cnt = dur;
            wr_st = 2;
          end else begin
            wr_cnt = lat - 1;
            wr_st = 1;
          end
        end
        1: begin
          wr_cnt--;
          if (wr_cnt == 0) begin
            bus.OVER = 1'b0;
            wr_cnt = dur;
            wr_st = 2;
          end
        end
        default: begin
          wr_cnt--;
          if (wr_cnt == 0) begin
            bus.OVER = 1'b1;
            wr_st = 0;
          end
        end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_init();
    exp_q.push_back({8'h00, 32'h0000_0000});
    exp_q.push_back({8'h01, 32'h00D0_0000});
    exp_q.push_back({8'h02, 32'h0000_0000});
    exp_q.push_back({8'h03, 32'h0000_0302});
  endtask

  // Reference: addresses 4/5/6 carry freq, zero-extended phase, and amp plus the 0x1000 enable bit.
  task automatic push_update(input logic [31:0] f, input logic [13:0] p, input logic [9:0] a);
    exp_q.push_back({8'h04, f});
    exp_q.push_back({8'h05, 32'(p)});
    exp_q.push_back({8'h06, 32'h0000_1000 + 32'(a)});
  endtask

  task automatic check_writes(input string tag);
    logic [39:0] e, g;
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk(tag, g, e);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic check_runs(input string tag, input int len, input int n);
    chk({tag, "_runs"}, 64'(tr_run_q.size()), 64'(n));
    foreach (tr_run_q[i]) chk({tag, "_tr_len"}, 64'(tr_run_q[i]), 64'(len));
    tr_run_q.delete();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_tr"}, bus.TR, 0);
    chk({tag, "_addr"}, bus.REG_ADDR, 0);
    chk({tag, "_data"}, bus.DATA_IN, 0);
    chk({tag, "_busy"}, bus.BUSY, 1);
    chk({tag, "_init_done"}, bus.INIT_DONE, 0);
    chk({tag, "_upd_done"}, bus.UPD_DONE, 0);
    chk({tag, "_err"}, bus.ERR, 0);
  endtask

  task automatic wait_idle(input string tag, output int np);
    int n = 0;
    np = 0;
    while (bus.BUSY !== 1'b0 && n < 2000) begin
      @(negedge CLK);
      n++;
      if (bus.UPD_DONE === 1'b1) np++;
    end
    chk({tag, "_in_time"}, 64'(n < 2000), 1);
    @(negedge CLK);
    if (bus.UPD_DONE === 1'b1) np++;
  endtask

  task automatic wait_pow(input string tag);
    int n = 0;
    while (!(bus.TR === 1'b1 && bus.REG_ADDR === 8'h05) && n < 500) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_reach_pow"}, 64'(n < 500), 1);
  endtask

  task automatic start_update(input logic [31:0] f, input logic [13:0] p, input logic [9:0] a);
    bus.FREQ_WORD = f;
    bus.PHASE_WORD = p;
    bus.AMP_WORD = a;
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    bus.FREQ_WORD = $urandom;
    bus.PHASE_WORD = 14'($urandom);
    bus.AMP_WORD = 10'($urandom);
  endtask

  task automatic do_init(input string tag);
    exp_q.delete();
    got_q.delete();
    tr_run_q.delete();
    push_init();
    @(negedge CLK);
    RESET_N = 1'b1;
    wait_idle(tag, pulses);
    chk({tag, "_init_done"}, bus.INIT_DONE, 1);
    chk({tag, "_busy"}, bus.BUSY, 0);
    chk({tag, "_err"}, bus.ERR, 0);
    chk({tag, "_no_upd"}, 64'(pulses), 0);
    check_writes(tag);
    check_runs(tag, lat, 4);
  endtask

  initial begin
    bus.START = 1'b0;
    bus.FREQ_WORD = '0;
    bus.PHASE_WORD = '0;
    bus.AMP_WORD = '0;
    repeat (3) @(negedge CLK);
    #1 check_reset("rst");

    // Init sequence after reset release.
    do_init("init");

    // Directed update with the reference words.
    push_update(32'h147AE148, 14'h1000, 10'h3FF);
    start_update(32'h147AE148, 14'h1000, 10'h3FF);
    wait_idle("upd", pulses);
    chk("upd_pulses", 64'(pulses), 1);
    chk("upd_busy", bus.BUSY, 0);
    check_writes("upd");

    // Randomized updates with a randomized writer pace.
    for (int k = 0; k < 6; k++) begin
      lat = $urandom_range(1, 8);
      dur = $urandom_range(1, 6);
      f0 = $urandom;
      p0 = 14'($urandom);
      a0 = 10'($urandom);
      tr_run_q.delete();
      push_update(f0, p0, a0);
      start_update(f0, p0, a0);
      wait_idle("rnd", pulses);
      chk("rnd_pulses", 64'(pulses), 1);
      check_writes("rnd");
      check_runs("rnd", lat, 3);
    end

    // START and a new FREQ_WORD during the phase write must not disturb the update.
    lat = 2;
    dur = 3;
    f0 = 32'hCAFE_0001;
    f1 = 32'h1234_5678;
    push_update(f0, 14'h0ABC, 10'h155);
    start_update(f0, 14'h0ABC, 10'h155);
    wait_pow("mid");
    bus.FREQ_WORD = f1;
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    wait_idle("mid", pulses);
    chk("mid_pulses", 64'(pulses), 1);
    repeat (10) @(negedge CLK);
    check_writes("mid");

    // Writer acknowledges five cycles after TR.
    lat = 5;
    dur = 3;
    tr_run_q.delete();
    push_update(32'h0F0F_0F0F, 14'h3FFF, 10'h000);
    start_update(32'h0F0F_0F0F, 14'h3FFF, 10'h000);
    wait_idle("slow", pulses);
    chk("slow_pulses", 64'(pulses), 1);
    check_writes("slow");
    check_runs("slow", 5, 3);

    // Writer never answers during an update: timeout.
    lat = 1;
    dur = 2;
    stall = 1'b1;
    tr_run_q.delete();
    start_update(32'hDEAD_BEEF, 14'h0001, 10'h001);
    wait_idle("to", pulses);
    chk("to_err", bus.ERR, 1);
    chk("to_tr", bus.TR, 0);
    chk("to_busy", bus.BUSY, 0);
    chk("to_pulses", 64'(pulses), 0);
    chk("to_init_kept", bus.INIT_DONE, 1);
    check_writes("to");
    check_runs("to", 64, 1);
    stall = 1'b0;
    push_update(32'h0000_0001, 14'h0002, 10'h003);
    start_update(32'h0000_0001, 14'h0002, 10'h003);
    wait_idle("post_to", pulses);
    chk("post_to_pulses", 64'(pulses), 1);
    check_writes("post_to");
    repeat (20) @(negedge CLK);
    chk("err_sticky", bus.ERR, 1);

    // Timeout during init leaves INIT_DONE low.
    RESET_N = 1'b0;
    #1 check_reset("rst2");
    stall = 1'b1;
    repeat (2) @(negedge CLK);
    got_q.delete();
    tr_run_q.delete();
    RESET_N = 1'b1;
    wait_idle("init_to", pulses);
    chk("init_to_err", bus.ERR, 1);
    chk("init_to_init_done", bus.INIT_DONE, 0);
    chk("init_to_busy", bus.BUSY, 0);
    check_writes("init_to");
    check_runs("init_to", 64, 1);

    // Reset in the middle of the phase write reruns init from CSR.
    stall = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    do_init("reinit");
    start_update(32'h5555_AAAA, 14'h2222, 10'h2AA);
    wait_pow("abort");
    #2 RESET_N = 1'b0;
    #1 check_reset("rst3");
    repeat (3) @(negedge CLK);
    do_init("restart");

    chk("tr_while_busy", 64'(viol), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end
endmodule
